par_serializer: RTL and testbench

PAR_SERIALIZER -- requirements
Module: par_serializer

---
 rtl/par_serializer_pkg.sv | 12 +
 rtl/par_serializer.sv | 95 +++++++++
 tb/tb_par_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/par_serializer_pkg.sv
// Shared definitions for the UART TX path: serializer FSM states and parity selectors.
package par_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/par_serializer.sv
// Parallel-to-serial shifter for the UART TX path: loads a word in IDLE,
// emits one registered bit per ser_en cycle and pulses ser_done with the last bit.
module par_serializer
  import par_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int PAR_TYPE   = PAR_EVEN
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  busy,
  output logic                  par_bit
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ser_data;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_par;

  logic                  w_next_bit;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_par;

  // The outgoing bit always sits at a fixed end of the register, so the
  // bit order is just a choice of shift direction.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_next_bit  = r_shift[0];
      assign w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_next_bit  = r_shift[DATA_WIDTH-1];
      assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign w_par = (PAR_TYPE == PAR_ODD) ? ~(^P_DATA) : (^P_DATA);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ser_data <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Data_Valid) begin
            r_shift <= P_DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_par   <= w_par;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            r_ser_data <= w_next_bit;
            r_shift    <= w_shift_nxt;
            // Counter stops at the last index; the next load clears it.
            if (r_cnt == LAST_IDX) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_data = r_ser_data;
  assign ser_done = r_done;
  assign busy     = r_busy;
  assign par_bit  = r_par;

endmodule

// File: tb/tb_par_serializer.sv
// Self-checking bench for par_serializer: table vectors plus a bit-queue scoreboard.
module tb_par_serializer;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid, ser_en;
  logic       ser_data, ser_done, busy, par_bit;

  logic [11:0] pd12;
  logic        dv12, en12;
  logic        sd12, done12, busy12, par12;

  par_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1), .PAR_TYPE(0)) u_dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .ser_en(ser_en),
    .ser_data(ser_data), .ser_done(ser_done), .busy(busy), .par_bit(par_bit)
  );

  par_serializer #(.DATA_WIDTH(12), .LSB_FIRST(0), .PAR_TYPE(1)) u_dut12 (
    .CLK(CLK), .RST(RST), .P_DATA(pd12), .Data_Valid(dv12), .ser_en(en12),
    .ser_data(sd12), .ser_done(done12), .busy(busy12), .par_bit(par12)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: bits of each accepted word queued in expected emission order.
  logic q_bits[$];
  logic m_busy = 1'b0;
  logic m_last = 1'b0;
  logic m_par  = 1'b0;

  task automatic step(input logic dv, input logic [7:0] pd, input logic en);
    logic e_done;
    Data_Valid = dv;
    P_DATA     = pd;
    ser_en     = en;
    e_done     = 1'b0;
    if (!m_busy && dv) begin
      for (int k = 0; k < 8; k++) q_bits.push_back(pd[k]);
      m_busy = 1'b1;
      m_par  = ^pd;
    end else if (m_busy && en) begin
      m_last = q_bits.pop_front();
      if (q_bits.size() == 0) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    chk("sb_ser_data", 32'(ser_data), 32'(m_last));
    chk("sb_ser_done", 32'(ser_done), 32'(e_done));
    chk("sb_busy",     32'(busy),     32'(m_busy));
    chk("sb_par_bit",  32'(par_bit),  32'(m_par));
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] pd;
    logic       en;
    logic       sd;
    logic       done;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic dv, input logic [7:0] pd, input logic en,
                              input logic sd, input logic done, input logic bsy);
    vec_t v;
    v.dv = dv; v.pd = pd; v.en = en; v.sd = sd; v.done = done; v.bsy = bsy;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0]  seq;
    logic [11:0] w12;

    // 0xA5 with ser_en held high: expected serial order written out literally
    add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    seq = 8'b1010_0101;
    for (int k = 0; k < 8; k++) add(1'b0, 8'h00, 1'b1, seq[7-k], k == 7, k != 7);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    // 0x3C with ser_en toggling
    add(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
    seq = 8'b0011_1100;
    for (int k = 0; k < 8; k++) begin
      add(1'b0, 8'h00, 1'b1, seq[7-k], k == 7, k != 7);
      if (k != 7) add(1'b0, 8'h00, 1'b0, seq[7-k], 1'b0, 1'b1);
    end

    RST = 1'b0; P_DATA = '0; Data_Valid = 1'b0; ser_en = 1'b0;
    pd12 = '0; dv12 = 1'b0; en12 = 1'b0;
    #2;
    chk("rst_ser_data", 32'(ser_data), 0);
    chk("rst_ser_done", 32'(ser_done), 0);
    chk("rst_busy",     32'(busy),     0);
    chk("rst_par_bit",  32'(par_bit),  0);
    chk("rst_busy12",   32'(busy12),   0);
    @(posedge CLK);
    #1 RST = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].dv, tbl[i].pd, tbl[i].en);
      chk("tbl_ser_data", 32'(ser_data), 32'(tbl[i].sd));
      chk("tbl_ser_done", 32'(ser_done), 32'(tbl[i].done));
      chk("tbl_busy",     32'(busy),     32'(tbl[i].bsy));
    end
    chk("tbl_par_3c", 32'(par_bit), 0);

    // Odd-weight word so par_bit must rise
    step(1'b1, 8'h07, 1'b0);
    chk("par_07", 32'(par_bit), 1);
    for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1);

    // Data_Valid during SHIFT is ignored; accepted in the ser_done cycle
    step(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 8'hFF, 1'b1);
    chk("b2b_done_seen", 32'(ser_done), 1);
    step(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("b2b_ones", 32'(ser_data), 1);
    end
    step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-word, three bits into 0xA5
    step(1'b1, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1);
    #1 RST = 1'b0;
    #1;
    chk("arst_ser_data", 32'(ser_data), 0);
    chk("arst_ser_done", 32'(ser_done), 0);
    chk("arst_busy",     32'(busy),     0);
    chk("arst_par_bit",  32'(par_bit),  0);
    q_bits.delete();
    m_busy = 1'b0; m_last = 1'b0; m_par = 1'b0;
    #2 RST = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 8'hFF, 1'b1);

    // 12-bit MSB-first, odd parity
    w12 = 12'h801;
    dv12 = 1'b1; pd12 = w12;
    @(posedge CLK);
    #1;
    dv12 = 1'b0; pd12 = '0;
    chk("w12_busy_load", 32'(busy12), 1);
    chk("w12_par",       32'(par12),  1);
    en12 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      chk("w12_ser_data", 32'(sd12),   32'(w12[11-k]));
      chk("w12_ser_done", 32'(done12), 32'(k == 11));
      chk("w12_busy",     32'(busy12), 32'(k != 11));
    end
    en12 = 1'b0;
    @(posedge CLK);
    #1;
    chk("w12_done_pulse", 32'(done12), 0);
    chk("w12_par_hold",   32'(par12),  1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
